// File: rtl/flash_word_reader_if.sv
// flash_word_reader_if: peripheral-bus read channel between a bus master and the flash reader
//   bus_addr  byte address of the word to read (master -> reader)
//   read_op   read request level, held until the data is consumed (master -> reader)
//   bus_data  last completed read word (reader -> master)
interface flash_word_reader_if #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic                  read_op;
  logic [DATA_WIDTH-1:0] bus_data;
  modport master (output bus_addr, output read_op, input bus_data);
  modport slave (input bus_addr, input read_op, output bus_data);
endinterface

// File: rtl/flash_word_reader.sv
// flash_word_reader: read-only 16-bit flash image serving 32-bit bus words as two half-word fetches
//   clk  40 MHz clock, all state on the rising edge
//   rst  asynchronous active-low reset (clears FSM, latched address and bus_data; array untouched)
//   bus  slave side of flash_word_reader_if (bus_addr, read_op in; registered bus_data out)
//   DEPTH_HW is taken as a power of two so the half-word index wraps by truncation.
module flash_word_reader #(
  parameter int    ADDR_WIDTH = 23,
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH_HW   = 4096,
  parameter string INIT_FILE  = "flash.mem"
) (
  input logic clk,
  input logic rst,
  flash_word_reader_if.slave bus
);
  localparam int HW = DATA_WIDTH / 2;
  localparam int IW = $clog2(DEPTH_HW);
  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, DONE} state_t;
  state_t                state, state_nxt;
  logic [HW-1:0]         mem [DEPTH_HW];
  logic [ADDR_WIDTH-1:0] addr;
  logic [HW-1:0]         lo_reg, hi_reg;
  logic                  load;
  logic [IW-1:0]         lo_idx, hi_idx;
  logic                  unused_addr;
  // word w lives at half-words 2w (lo) and 2w+1 (hi); higher address bits wrap away
  assign lo_idx = {addr[IW:2], 1'b0};
  assign hi_idx = {addr[IW:2], 1'b1};
  assign unused_addr = ^{addr[ADDR_WIDTH-1:IW+1], addr[1:0]};
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  // DONE is left only on a low read_op sample, so a level held high reads once
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE  ? (bus.read_op ? RD_LO : IDLE) :
                state == RD_LO ? RD_HI :
                state == RD_HI ? DONE :
                                 (bus.read_op ? DONE : IDLE);
  end
  // load marks the first cycle in DONE, the only point bus_data may change
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      addr         <= '0;
      lo_reg       <= '0;
      hi_reg       <= '0;
      load         <= 1'b0;
      bus.bus_data <= '0;
    end else begin
      if (state == IDLE && bus.read_op) addr <= bus.bus_addr;
      if (state == RD_LO) lo_reg <= mem[lo_idx];
      if (state == RD_HI) hi_reg <= mem[hi_idx];
      load <= state == RD_HI;
      if (load) bus.bus_data <= {hi_reg, lo_reg};
    end
endmodule

// File: tb/tb_flash_word_reader.sv
// tb_flash_word_reader: randomized and directed bench with a transaction-level model of the flash reader
module tb_flash_word_reader;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int D  = 4096;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  flash_word_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  flash_word_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_HW(D), .INIT_FILE("")) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  logic [15:0] img [D];
  int          n_chk  = 0;
  int          n_fail = 0;
  bit          mdl_on = 1'b0;
  bit          lit_en = 1'b0;
  string       lit_name;
  logic [31:0] lit_val;
  int          cyc = 0;
  bit          idle = 1'b1;
  int          acc = 0;
  logic [31:0] exp_data = '0;
  logic [31:0] pend = '0;
  function automatic logic [31:0] word_at(input logic [AW-1:0] a);
    int w;
    w = int'(a >> 2);
    return {img[(2*w+1) % D], img[(2*w) % D]};
  endfunction
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: bus_data=%h expected=%h at %0t", nm, got, want, $time);
    end
  endtask
  // A read is accepted when the reader is free and read_op is high; its word
  // appears 3 edges later and the reader frees up on the first low sample from then on.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst) begin
      idle = 1'b1;
      exp_data = '0;
    end else if (idle) begin
      if (bus.read_op) begin
        idle = 1'b0;
        acc = cyc;
        pend = word_at(bus.bus_addr);
      end
    end else if (cyc >= acc + 3) begin
      if (cyc == acc + 3) exp_data = pend;
      if (!bus.read_op) idle = 1'b1;
    end
  end
  initial forever begin
    @(negedge clk);
    #2;
    if (mdl_on) check("model", bus.bus_data, rst ? exp_data : 32'h0);
    if (lit_en) check(lit_name, bus.bus_data, lit_val);
  end
  task automatic drive(input logic r, input logic [AW-1:0] a);
    @(negedge clk);
    bus.read_op = r;
    bus.bus_addr = a;
  endtask
  task automatic expect_lit(input string nm, input logic [31:0] v);
    @(negedge clk);
    lit_name = nm;
    lit_val = v;
    lit_en = 1'b1;
    #3;
    lit_en = 1'b0;
  endtask
  task automatic rd(input logic [AW-1:0] a, input logic [31:0] v, input string nm);
    repeat (4) drive(1'b1, a);
    expect_lit(nm, v);
    drive(1'b0, a);
  endtask
  initial begin
    int sw[] = '{0, 4, 5, 6, 7, 8, 12, 100, 2044, 2*D-4, 2*D, 2*D+4, 4*D-4, 8188};
    rst = 1'b1;
    bus.read_op = 1'b0;
    bus.bus_addr = '0;
    for (int i = 0; i < D; i++) img[i] = 16'($urandom);
    img[0] = 16'h5678;
    img[1] = 16'h1234;
    img[2] = 16'hBEEF;
    img[3] = 16'hDEAD;
    img[D-2] = 16'h0002;
    img[D-1] = 16'h0001;
    for (int i = 0; i < D; i++) dut.mem[i] = img[i];
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    mdl_on = 1'b1;
    expect_lit("reset", 32'h0);
    @(negedge clk);
    rst = 1'b1;
    rd(AW'(0), 32'h12345678, "addr0");
    rd(AW'(4), 32'hDEADBEEF, "addr4");
    rd(AW'(5), 32'hDEADBEEF, "addr5_low_bits");
    rd(AW'(2*D-4), 32'h00010002, "top_word");
    rd(AW'(2*D), 32'h12345678, "wrap");
    rd(AW'(4), 32'hDEADBEEF, "addr4_again");
    drive(1'b1, AW'(0));
    repeat (8) drive(1'b1, AW'(4));
    expect_lit("addr_change_held", 32'h12345678);
    drive(1'b0, AW'(4));
    rd(AW'(2*D-4), 32'h00010002, "top_word_again");
    drive(1'b1, AW'(4));
    repeat (3) drive(1'b0, AW'(0));
    expect_lit("drop_mid_read", 32'hDEADBEEF);
    drive(1'b0, AW'(0));
    drive(1'b1, AW'(0));
    @(posedge clk);
    #2 rst = 1'b0;
    expect_lit("rst_mid_read", 32'h0);
    drive(1'b0, AW'(0));
    rst = 1'b1;
    repeat (5) drive(1'b0, AW'(0));
    expect_lit("rst_no_partial", 32'h0);
    rd(AW'(0), 32'h12345678, "after_reset");
    repeat (600) begin
      @(negedge clk);
      rst = $urandom_range(0, 99) != 0;
      bus.read_op = $urandom_range(0, 2) != 0;
      bus.bus_addr = $urandom_range(0, 1) != 0 ? AW'($urandom) : AW'($urandom_range(0, 2*D+8));
    end
    @(negedge clk);
    rst = 1'b1;
    bus.read_op = 1'b0;
    repeat (2) @(negedge clk);
    foreach (sw[i]) begin
      repeat (3) drive(1'b1, AW'(sw[i]));
      drive(1'b0, AW'(sw[i]));
    end
    for (int i = 0; i < 20; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom);
      repeat (3) drive(1'b1, a);
      drive(1'b0, a);
    end
    repeat (6) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
